// File: rtl/regfile_sb.sv
// Integer register file with two combinational read ports, one write port, optional
// write-to-read bypass, a pending-write scoreboard and a post-reset init sequencer.
module regfile_sb #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 5,
    parameter int BYPASS    = 1,
    parameter int INIT_MODE = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [ADDR_W-1:0] rd_addr1,
    output logic [DATA_W-1:0] rd_data1,
    input  logic [ADDR_W-1:0] rd_addr2,
    output logic [DATA_W-1:0] rd_data2,
    output logic              busy1,
    output logic              busy2,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              issue_en,
    input  logic [ADDR_W-1:0] issue_addr,
    output logic              ready
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] ZERO_ADDR = {ADDR_W{1'b0}};

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t            state_r;
    state_t            state_next_s;
    logic [ADDR_W-1:0] init_cnt_r;
    logic              ready_r;
    logic [DEPTH-1:0]  busy_r;
    logic [DEPTH-1:0]  busy_next_s;
    logic [DATA_W-1:0] mem_r [DEPTH];
    logic              mem_we_s;
    logic [ADDR_W-1:0] mem_waddr_s;
    logic [DATA_W-1:0] mem_wdata_s;

    function automatic logic [DATA_W-1:0] init_value(input logic [ADDR_W-1:0] idx);
        if (INIT_MODE == 1) begin
            return DATA_W'(idx);
        end else begin
            return {DATA_W{1'b0}};
        end
    endfunction

    // Next-state: INIT walks registers 1..DEPTH-1, then RUN until reset.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_INIT: begin
                if (init_cnt_r == LAST_ADDR) begin
                    state_next_s = ST_RUN;
                end else begin
                    state_next_s = ST_INIT;
                end
            end
            ST_RUN:  state_next_s = ST_RUN;
            default: state_next_s = ST_INIT;
        endcase
    end

    // State, init counter and ready flag.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r    <= ST_INIT;
            init_cnt_r <= ADDR_W'(1);
            ready_r    <= 1'b0;
        end else begin
            state_r <= state_next_s;
            ready_r <= (state_next_s == ST_RUN);
            if (state_r == ST_INIT) begin
                init_cnt_r <= init_cnt_r + ADDR_W'(1);
            end else begin
                init_cnt_r <= init_cnt_r;
            end
        end
    end

    // Array write source: the init sequencer owns the port until RUN.
    always_comb begin
        mem_we_s    = 1'b0;
        mem_waddr_s = ZERO_ADDR;
        mem_wdata_s = {DATA_W{1'b0}};
        if (reset) begin
            mem_we_s = 1'b0;
        end else if (state_r == ST_INIT) begin
            mem_we_s    = 1'b1;
            mem_waddr_s = init_cnt_r;
            mem_wdata_s = init_value(init_cnt_r);
        end else if (wr_en && (wr_addr != ZERO_ADDR)) begin
            mem_we_s    = 1'b1;
            mem_waddr_s = wr_addr;
            mem_wdata_s = wr_data;
        end else begin
            mem_we_s = 1'b0;
        end
    end

    // Register array; contents deliberately survive reset.
    always_ff @(posedge clock) begin
        if (mem_we_s) begin
            mem_r[mem_waddr_s] <= mem_wdata_s;
        end
    end

    // Scoreboard update: clear on writeback, then set on issue so a same-address set wins.
    always_comb begin
        busy_next_s = busy_r;
        if (state_r == ST_RUN) begin
            if (wr_en && (wr_addr != ZERO_ADDR)) begin
                busy_next_s[wr_addr] = 1'b0;
            end
            if (issue_en && (issue_addr != ZERO_ADDR)) begin
                busy_next_s[issue_addr] = 1'b1;
            end
        end else begin
            busy_next_s = busy_r;
        end
        busy_next_s[0] = 1'b0;
    end

    // Scoreboard register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            busy_r <= {DEPTH{1'b0}};
        end else begin
            busy_r <= busy_next_s;
        end
    end

    // Read ports: zero outside RUN and for register 0; optional same-cycle forwarding.
    always_comb begin
        rd_data1 = {DATA_W{1'b0}};
        rd_data2 = {DATA_W{1'b0}};
        if ((state_r != ST_RUN) || (rd_addr1 == ZERO_ADDR)) begin
            rd_data1 = {DATA_W{1'b0}};
        end else if ((BYPASS != 0) && wr_en && (wr_addr == rd_addr1)) begin
            rd_data1 = wr_data;
        end else begin
            rd_data1 = mem_r[rd_addr1];
        end
        if ((state_r != ST_RUN) || (rd_addr2 == ZERO_ADDR)) begin
            rd_data2 = {DATA_W{1'b0}};
        end else if ((BYPASS != 0) && wr_en && (wr_addr == rd_addr2)) begin
            rd_data2 = wr_data;
        end else begin
            rd_data2 = mem_r[rd_addr2];
        end
    end

    // Busy lookups show the registered scoreboard only.
    always_comb begin
        busy1 = 1'b0;
        busy2 = 1'b0;
        if (state_r == ST_RUN) begin
            busy1 = busy_r[rd_addr1];
            busy2 = busy_r[rd_addr2];
        end else begin
            busy1 = 1'b0;
            busy2 = 1'b0;
        end
    end

    assign ready = ready_r;

endmodule

// File: tb/tb_regfile_sb.sv
// Scoreboard bench for regfile_sb: drives a bypass and a non-bypass build with shared
// stimulus and compares both against a behavioural register-file model.
module tb_regfile_sb;

    logic        clock = 1'b1;
    logic        reset = 1'b1;
    logic [4:0]  rd_addr1 = 5'd0, rd_addr2 = 5'd0, wr_addr = 5'd0, issue_addr = 5'd0;
    logic [31:0] wr_data = 32'd0;
    logic        wr_en = 1'b0, issue_en = 1'b0;

    logic [31:0] a_rd1, a_rd2, b_rd1, b_rd2;
    logic        a_busy1, a_busy2, b_busy1, b_busy2, a_ready, b_ready;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] rd1_a, rd2_a, rd1_b, rd2_b;
        logic        busy1, busy2, rdy;
    } exp_t;
    exp_t exp_q[$];

    // Reference model state
    logic [31:0] m_regs [32];
    bit          m_busy [32];
    bit          m_ready;
    int          m_init_done;

    regfile_sb #(.DATA_W(32), .ADDR_W(5), .BYPASS(1), .INIT_MODE(1)) u_byp (
        .clock(clock), .reset(reset),
        .rd_addr1(rd_addr1), .rd_data1(a_rd1), .rd_addr2(rd_addr2), .rd_data2(a_rd2),
        .busy1(a_busy1), .busy2(a_busy2),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .issue_en(issue_en), .issue_addr(issue_addr), .ready(a_ready));

    regfile_sb #(.DATA_W(32), .ADDR_W(5), .BYPASS(0), .INIT_MODE(1)) u_nob (
        .clock(clock), .reset(reset),
        .rd_addr1(rd_addr1), .rd_data1(b_rd1), .rd_addr2(rd_addr2), .rd_data2(b_rd2),
        .busy1(b_busy1), .busy2(b_busy2),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .issue_en(issue_en), .issue_addr(issue_addr), .ready(b_ready));

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic m_reset();
        m_ready     = 1'b0;
        m_init_done = 0;
        for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
    endtask

    function automatic logic [31:0] m_read(input logic [4:0] a, input bit bypass);
        if (!m_ready || a == 5'd0) return 32'd0;
        if (bypass && wr_en && wr_addr == a) return wr_data;
        return m_regs[a];
    endfunction

    // Apply current inputs to the model as one rising edge.
    task automatic m_edge();
        if (reset) return;
        if (!m_ready) begin
            m_init_done++;
            m_regs[m_init_done] = 32'(m_init_done);
            if (m_init_done == 31) m_ready = 1'b1;
        end else begin
            if (wr_en && wr_addr != 5'd0) begin
                m_regs[wr_addr] = wr_data;
                m_busy[wr_addr] = 1'b0;
            end
            if (issue_en && issue_addr != 5'd0) m_busy[issue_addr] = 1'b1;
        end
    endtask

    task automatic step(input bit rst, input logic [4:0] r1, input logic [4:0] r2,
                        input bit we, input logic [4:0] wa, input logic [31:0] wd,
                        input bit ie, input logic [4:0] ia);
        exp_t e;
        reset = rst; rd_addr1 = r1; rd_addr2 = r2;
        wr_en = we; wr_addr = wa; wr_data = wd; issue_en = ie; issue_addr = ia;
        if (rst) m_reset();
        e.rd1_a = m_read(r1, 1'b1);
        e.rd2_a = m_read(r2, 1'b1);
        e.rd1_b = m_read(r1, 1'b0);
        e.rd2_b = m_read(r2, 1'b0);
        e.busy1 = m_ready ? m_busy[r1] : 1'b0;
        e.busy2 = m_ready ? m_busy[r2] : 1'b0;
        e.rdy   = m_ready;
        exp_q.push_back(e);
        @(posedge clock);
        m_edge();
        #1;
    endtask

    task automatic idle(input logic [4:0] r1, input logic [4:0] r2);
        step(1'b0, r1, r2, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
    endtask

    // Monitor: outputs are settled mid-cycle; pop one expectation per falling edge.
    always @(negedge clock) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("ready_a", {31'd0, a_ready}, {31'd0, e.rdy});
            check("ready_b", {31'd0, b_ready}, {31'd0, e.rdy});
            check("rd_data1_byp", a_rd1, e.rd1_a);
            check("rd_data2_byp", a_rd2, e.rd2_a);
            check("rd_data1_nobyp", b_rd1, e.rd1_b);
            check("rd_data2_nobyp", b_rd2, e.rd2_b);
            check("busy1", {31'd0, a_busy1}, {31'd0, e.busy1});
            check("busy2", {31'd0, a_busy2}, {31'd0, e.busy2});
            check("busy1_nobyp", {31'd0, b_busy1}, {31'd0, e.busy1});
            check("busy2_nobyp", {31'd0, b_busy2}, {31'd0, e.busy2});
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [4:0]  r1, r2, wa, ia;
        logic [31:0] wd;
        bit          we, ie, rst;
        m_reset();
        for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
        #2;
        // Reset, then 31 init edges with writes and issues to register 3 that must be ignored
        step(1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
        for (int i = 0; i < 31; i++) step(1'b0, 5'd3, 5'd7, 1'b1, 5'd3, 32'hFFFF, 1'b1, 5'd3);
        idle(5'd7, 5'd31);
        idle(5'd0, 5'd3);
        // Abort init after 10 edges, then full re-init
        step(1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
        for (int i = 0; i < 10; i++) idle(5'd1, 5'd2);
        step(1'b1, 5'd1, 5'd2, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
        for (int i = 0; i < 31; i++) idle(5'd1, 5'd31);
        for (int i = 0; i < 16; i++) idle(5'(i), 5'(i + 16));
        // Bypass: same-cycle write/read, then read after the edge; write to register 0
        step(1'b0, 5'd5, 5'd5, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0);
        idle(5'd5, 5'd4);
        step(1'b0, 5'd0, 5'd0, 1'b1, 5'd0, 32'h12345678, 1'b0, 5'd0);
        idle(5'd0, 5'd5);
        // Non-bypass build: old value until the edge
        step(1'b0, 5'd12, 5'd12, 1'b1, 5'd12, 32'hFFFF, 1'b0, 5'd0);
        idle(5'd12, 5'd11);
        // Scoreboard: set, clear, simultaneous set+clear, issue to register 0
        step(1'b0, 5'd9, 5'd9, 1'b0, 5'd0, 32'd0, 1'b1, 5'd9);
        step(1'b0, 5'd9, 5'd10, 1'b1, 5'd9, 32'h99, 1'b0, 5'd0);
        idle(5'd9, 5'd9);
        step(1'b0, 5'd9, 5'd9, 1'b1, 5'd9, 32'h77, 1'b1, 5'd9);
        step(1'b0, 5'd9, 5'd10, 1'b1, 5'd10, 32'hAA, 1'b1, 5'd9);
        step(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd0);
        idle(5'd0, 5'd9);
        // Randomized traffic with address collisions and rare resets
        for (int n = 0; n < 2500; n++) begin
            rst = ($urandom_range(0, 399) == 0);
            wa  = 5'($urandom_range(0, 31));
            ia  = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
            r1  = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
            r2  = ($urandom_range(0, 3) == 0) ? ia : 5'($urandom_range(0, 31));
            we  = ($urandom_range(0, 1) == 1);
            ie  = ($urandom_range(0, 2) == 0);
            wd  = $urandom;
            step(rst, r1, r2, we, wa, wd, ie, ia);
        end
        idle(5'd0, 5'd0);
        @(negedge clock);
        #1;
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
- Parametrised successor to the single-read integer register file: two combinational read ports, one clocked write port, and register 0 hardwired to zero.
- Adds optional write-to-read bypass, a per-register pending-write scoreboard (busy bits) for the issue stage, and a reset init sequencer that loads registers one per cycle and then raises ready.
- Sits between decode/issue (reads, issue marks) and writeback (writes) in the core.

Parameters:
- DATA_W, 32, register width in bits.
- ADDR_W, 5, register address width; DEPTH = 2**ADDR_W registers (derived, not overridable).
- BYPASS, 1, 1 = a same-cycle write is forwarded to matching read ports; 0 = reads see array contents only.
- INIT_MODE, 1, init value of register i: 0 = all zero; 1 = i zero-extended to DATA_W.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- rd_addr1  in  ADDR_W  read port 1 address.
- rd_data1  out  DATA_W  read port 1 data (combinational).
- rd_addr2  in  ADDR_W  read port 2 address.
- rd_data2  out  DATA_W  read port 2 data (combinational).
- busy1  out  1  scoreboard bit for rd_addr1 (combinational).
- busy2  out  1  scoreboard bit for rd_addr2 (combinational).
- wr_en  in  1  writeback strobe.
- wr_addr  in  ADDR_W  writeback register.
- wr_data  in  DATA_W  writeback data.
- issue_en  in  1  marks issue_addr as having a pending write.
- issue_addr  in  ADDR_W  destination of the issuing instruction.
- ready  out  1  init complete; the block accepts traffic.

Behaviour:
- States: INIT, RUN. Reset (async) forces INIT, init counter = 1, all busy bits = 0, ready = 0. Array contents are not cleared by reset itself.
- INIT:
  - Each rising edge with reset low writes the init value (per INIT_MODE) to register[counter], then counter increments.
  - The edge that writes register DEPTH-1 moves the block to RUN and sets ready = 1. Ready is therefore high after exactly DEPTH-1 clock edges following reset release (31 for the defaults).
  - wr_en and issue_en are ignored. rd_data1/2 = 0 and busy1/2 = 0.
- RUN:
  - ready stays 1 until the next reset.
  - Reset asserted at any point, including mid-INIT, aborts immediately and restarts INIT from register 1.
- Reads, RUN only:
  - rd_dataN = register[rd_addrN]; address 0 always returns 0.
  - If BYPASS=1, wr_en=1, wr_addr==rd_addrN and wr_addr!=0, rd_dataN = wr_data in the same cycle.
  - Both ports may hit the same address, or the write address, simultaneously; each port resolves independently.
- Write: on a rising edge in RUN with wr_en=1 and wr_addr!=0, register[wr_addr] <= wr_data. Writes to register 0 are discarded.
- Scoreboard, RUN, per rising edge:
  - issue_en=1 and issue_addr!=0: busy[issue_addr] <= 1.
  - wr_en=1 and wr_addr!=0: busy[wr_addr] <= 0.
  - Same address on both in the same cycle: set wins, because the new pending write supersedes.
  - Different addresses: both take effect.
  - busy[0] is constant 0.
  - busyN = busy[rd_addrN], registered value only; no bypass of a same-cycle clear or set.
- Issuing to an already-busy register leaves it busy. No counting: one write clears it.
- Widths: all addresses are unsigned. No truncation or extension of data except the INIT_MODE zero-extension.

Test Plan:
- Reset pulse, then hold reset low: ready=0 for 31 edges and 1 after edge 31; afterwards rd_addr1=7 -> rd_data1=0x7, rd_addr2=31 -> 0x1F, rd_addr1=0 -> 0.
- Reset re-asserted after 10 init edges: ready drops and stays 0; after release ready rises only after a full 31 further edges and every register reads its index.
- RUN, BYPASS=1: wr_en=1, wr_addr=5, wr_data=0xDEADBEEF, rd_addr1=5 in the same cycle -> rd_data1=0xDEADBEEF before the edge and also after it. Repeat with wr_addr=0 -> rd_data1 reads 0 throughout.
- Scoreboard: issue 9 -> busy1(rd_addr1=9)=1 next cycle; write 9 -> busy1=0 next cycle. Issue 9 and write 9 in the same cycle -> busy1 stays 1. Issue 0 -> busy stays 0.
- Init phase: wr_en=1, wr_addr=3, wr_data=0xFFFF and issue_en=1, issue_addr=3 during INIT -> after ready, register 3 reads 0x3 and busy is 0.
- BYPASS=0 build: same-cycle write and read of register 12 -> old value 0xC until the edge, 0xFFFF after it.
